// File: rtl/byte_packer_pkg.sv
// Shared types and defaults for the byte packer block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package byte_packer_pkg;

    // FILL accumulates lanes, HOLD owns a finished word awaiting its FIFO write
    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int DEF_BW = 8;
    localparam int DEF_DW = 32;

    // Lane index width; a single-lane build still needs a 1-bit counter
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

endpackage

// File: rtl/byte_packer_if.sv
// Byte stream in, packed word out towards a FIFO write port.
// Latency: n/a (wiring only).
// Backpressure: in_ready upstream, full from the FIFO downstream.
interface byte_packer_if
    import byte_packer_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int BW = DEF_BW
);
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          in_last;
    logic          full;
    logic          wr_en;
    logic [DW-1:0] data_out;

    // Packer side
    modport slave (
        input  in_valid, in_data, in_last, full,
        output in_ready, wr_en, data_out
    );

    // Byte source / FIFO side
    modport master (
        output in_valid, in_data, in_last, full,
        input  in_ready, wr_en, data_out
    );
endinterface

// File: rtl/byte_packer_lane_counter.sv
// Lane index for the packer: counts accepted bytes 0..LANES-1 and wraps.
// Latency: new index visible the cycle after inc/clr.
// Backpressure: none; the caller only pulses inc on accepted bytes.
module lane_counter
    import byte_packer_pkg::*;
#(
    parameter  int LANES = 4,
    localparam int LW    = lane_bits(LANES)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          inc,
    input  logic          clr,
    output logic [LW-1:0] lane,
    output logic          at_top
);
    localparam logic [LW-1:0] TOP = LW'(LANES - 1);

    assign at_top = (lane == TOP);

    // Advance per accepted byte; wrap after the top lane, early clear on flush
    always_ff @(posedge clk) begin
        if (!rstn) begin
            lane <= '0;
        end else if (clr || (inc && at_top)) begin
            lane <= '0;
        end else if (inc) begin
            lane <= lane + LW'(1);
        end
    end
endmodule

// File: rtl/byte_packer.sv
// Packs BW-bit bytes little-endian into DW-bit words and writes them to a FIFO; PACKER_FLUSH_EN lets in_last close a word early.
// Latency: wr_en possible the cycle after a word's final byte is accepted; one byte/cycle sustained.
// Backpressure: while a word is held and full=1, in_ready and wr_en are both low.
module byte_packer
    import byte_packer_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int BW = DEF_BW
) (
    input  logic               clk,
    input  logic               rstn,
    byte_packer_if.slave       bus,
    output logic [15:0]        word_cnt
);
    localparam int LANES = DW / BW;
    localparam int LW    = lane_bits(LANES);

    state_t        state;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic [DW-1:0] out_q;
    logic [LW-1:0] lane;
    logic          at_top;
    logic          rdy;
    logic          wr;
    logic          accept;
    logic          flush;
    logic          complete;

    // A held word blocks input only when the FIFO cannot take it this cycle,
    // so any byte accepted in HOLD coincides with the write that frees it.
    assign wr       = (state == HOLD) && !bus.full;
    assign rdy      = !((state == HOLD) && bus.full);
    assign accept   = bus.in_valid && rdy;

`ifdef PACKER_FLUSH_EN
    assign flush    = accept && bus.in_last;
`else
    logic unused_last;
    assign unused_last = bus.in_last;
    assign flush    = 1'b0;
`endif

    assign complete = accept && (at_top || flush);

    assign bus.in_ready = rdy;
    assign bus.wr_en    = wr;
    assign bus.data_out = out_q;

    lane_counter #(.LANES(LANES)) u_lane (
        .clk    (clk),
        .rstn   (rstn),
        .inc    (accept),
        .clr    (flush),
        .lane   (lane),
        .at_top (at_top)
    );

    // Drop the incoming byte into its lane; unused upper lanes stay zero
    // because the accumulator is cleared whenever a word leaves it.
    always_comb begin
        acc_next = acc;
        acc_next[int'(lane)*BW +: BW] = bus.in_data;
    end

    // Accumulate bytes; a completing byte moves the whole word to the output register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc   <= '0;
            out_q <= '0;
        end else if (accept) begin
            if (complete) begin
                out_q <= acc_next;
                acc   <= '0;
            end else begin
                acc   <= acc_next;
            end
        end
    end

    // FILL/HOLD control; a word completing on the write cycle keeps us in HOLD
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= FILL;
        end else begin
            case (state)
                FILL:    if (complete)        state <= HOLD;
                HOLD:    if (wr && !complete) state <= FILL;
                default:                      state <= FILL;
            endcase
        end
    end

    // Count FIFO writes, wrapping at 16 bits
    always_ff @(posedge clk) begin
        if (!rstn) begin
            word_cnt <= '0;
        end else if (wr) begin
            word_cnt <= word_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_byte_packer.sv
// Self-checking bench for byte_packer: directed scenarios plus random traffic against a byte-stream model.
// Latency: model predicts a write the cycle after a word's final byte.
// Backpressure: random full toggling; model predicts in_ready/wr_en each cycle.
module tb_byte_packer;
    import byte_packer_pkg::*;

    localparam int DW    = 32;
    localparam int BW    = 8;
    localparam int LANES = DW / BW;
`ifdef PACKER_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic [15:0] word_cnt;

    byte_packer_if #(.DW(DW), .BW(BW)) bus ();

    byte_packer #(.DW(DW), .BW(BW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .bus      (bus),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: stream of accepted bytes grouped into words
    logic [BW-1:0] part_q[$];
    logic [DW-1:0] exp_q[$];
    logic [15:0]   m_cnt;

    // Observations from the most recent cycle
    logic          o_wr;
    logic          o_rdy;
    logic [DW-1:0] o_dat;
    int            cyc_n = 0;
    int            wr_cyc[$];
    logic [DW-1:0] wr_dat[$];

    function automatic logic [DW-1:0] pack_bytes();
        logic [DW-1:0] w = '0;
        foreach (part_q[k]) w = w + (DW'(part_q[k]) << (BW * k));
        return w;
    endfunction

    // One clock: drive inputs just after posedge, sample/check at negedge
    task automatic cyc(input logic v, input logic [BW-1:0] d, input logic l, input logic f);
        bit held;
        bit e_wr;
        bit e_rdy;
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_last  = l;
        bus.full     = f;
        @(negedge clk);
        o_wr  = bus.wr_en;
        o_rdy = bus.in_ready;
        o_dat = bus.data_out;
        held  = (exp_q.size() > 0);
        e_wr  = held && !f;
        e_rdy = !(held && f);
        check("word_cnt", word_cnt, m_cnt);
        check("wr_en", o_wr, e_wr);
        check("in_ready", o_rdy, e_rdy);
        if (held) check("data_out", o_dat, exp_q[0]);
        if (o_wr) begin
            wr_cyc.push_back(cyc_n);
            wr_dat.push_back(o_dat);
        end
        if (e_wr) begin
            void'(exp_q.pop_front());
            m_cnt = m_cnt + 16'd1;
        end
        if (v && e_rdy) begin
            part_q.push_back(d);
            if (part_q.size() == LANES || (FLUSH && l)) begin
                exp_q.push_back(pack_bytes());
                part_q.delete();
            end
        end
        cyc_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rstn         = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.full     = 1'b0;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        part_q.delete();
        exp_q.delete();
        m_cnt = 16'd0;
        wr_cyc.delete();
        wr_dat.delete();
        check("rst_wr_en", bus.wr_en, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_data_out", bus.data_out, '0);
        check("rst_word_cnt", word_cnt, 16'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic rdy_all;
        rstn         = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.in_last  = 1'b0;
        bus.full     = 1'b0;
        @(posedge clk);
        #1;

        // Single word, consecutive bytes
        do_reset();
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(1, 8'h44, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t1_wr_en", o_wr, 1'b1);
        check("t1_data", o_dat, 32'h44332211);
        check("t1_word_cnt", word_cnt, 16'd1);

        // Two words back to back at full rate
        do_reset();
        rdy_all = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1, BW'(i), 0, 0);
            rdy_all = rdy_all & o_rdy;
        end
        cyc(0, 8'h00, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t2_rdy_held", rdy_all, 1'b1);
        check("t2_n_writes", wr_cyc.size(), 2);
        if (wr_cyc.size() == 2) begin
            check("t2_gap", wr_cyc[1] - wr_cyc[0], 4);
            check("t2_word0", wr_dat[0], 32'h04030201);
            check("t2_word1", wr_dat[1], 32'h08070605);
        end
        check("t2_word_cnt", word_cnt, 16'd2);

        // Word completes while the FIFO is full
        do_reset();
        cyc(1, 8'hA1, 0, 0);
        cyc(1, 8'hA2, 0, 0);
        cyc(1, 8'hA3, 0, 1);
        cyc(1, 8'hA4, 0, 1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 8'h55, 0, 1);
            check("t3_wr_blocked", o_wr, 1'b0);
            check("t3_rdy_blocked", o_rdy, 1'b0);
            check("t3_stable", o_dat, 32'hA4A3A2A1);
        end
        cyc(1, 8'h55, 0, 0);
        check("t3_wr_release", o_wr, 1'b1);
        check("t3_data_release", o_dat, 32'hA4A3A2A1);
        cyc(1, 8'h66, 0, 0);
        cyc(1, 8'h77, 0, 0);
        cyc(1, 8'h88, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t3_next_word", o_dat, 32'h88776655);

        // Early close with in_last
        do_reset();
        cyc(1, 8'hAA, 0, 0);
        cyc(1, 8'hBB, 1, 0);
        cyc(0, 8'h00, 0, 0);
`ifdef PACKER_FLUSH_EN
        check("t4_flush_wr", o_wr, 1'b1);
        check("t4_flush_data", o_dat, 32'h0000BBAA);
`else
        check("t4_no_flush_wr", o_wr, 1'b0);
        cyc(1, 8'hCC, 0, 0);
        cyc(1, 8'hDD, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t4_full_wr", o_wr, 1'b1);
        check("t4_full_data", o_dat, 32'hDDCCBBAA);
`endif

        // Reset mid-word discards the partial word
        do_reset();
        cyc(1, 8'h99, 0, 0);
        cyc(1, 8'h98, 0, 0);
        do_reset();
        cyc(1, 8'h11, 0, 0);
        cyc(1, 8'h22, 0, 0);
        cyc(1, 8'h33, 0, 0);
        cyc(1, 8'h44, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t5_wr_en", o_wr, 1'b1);
        check("t5_data", o_dat, 32'h44332211);
        cyc(0, 8'h00, 0, 0);
        check("t5_word_cnt", word_cnt, 16'd1);
        check("t5_n_writes", wr_cyc.size(), 1);

        // Reset while a word is held under full
        cyc(1, 8'h01, 0, 1);
        cyc(1, 8'h02, 0, 1);
        cyc(1, 8'h03, 0, 1);
        cyc(1, 8'h04, 0, 1);
        cyc(1, 8'h05, 0, 1);
        check("t6_held", o_rdy, 1'b0);
        do_reset();

        // Random traffic with random backpressure and in_last
        for (int i = 0; i < 3000; i++) begin
            cyc(logic'($urandom_range(0, 3) != 0), BW'($urandom),
                logic'($urandom_range(0, 7) == 0), logic'($urandom_range(0, 9) < 3));
        end
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 0, 0);

        // Counter wrap from 0xFFFF
        do_reset();
        #2;
        force dut.word_cnt = 16'hFFFF;
        #1;
        release dut.word_cnt;
        #1;
        m_cnt = 16'hFFFF;
        check("t7_preset", word_cnt, 16'hFFFF);
        @(posedge clk);
        #1;
        cyc(1, 8'hDE, 0, 0);
        cyc(1, 8'hAD, 0, 0);
        cyc(1, 8'hBE, 0, 0);
        cyc(1, 8'hEF, 0, 0);
        cyc(0, 8'h00, 0, 0);
        check("t7_wrap", word_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/byte_packer.md
BYTE_PACKER -- requirements
Module: byte_packer

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the width of the packed output word in bits.
REQ-002 The block SHALL have parameter BW, default 8, meaning the input byte width in bits; DW SHALL be an integer multiple of BW, and LANES = DW/BW.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rstn, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: upstream byte valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a byte this cycle.
REQ-007 The block SHALL have port in_data, input, BW bits: input byte.
REQ-008 The block SHALL have port in_last, input, 1 bit: this byte closes the current word (used only per REQ-026).
REQ-009 The block SHALL have port full, input, 1 bit: downstream FIFO full.
REQ-010 The block SHALL have port wr_en, output, 1 bit: FIFO write strobe.
REQ-011 The block SHALL have port data_out, output, DW bits: word presented to the FIFO.
REQ-012 The block SHALL have port word_cnt, output, 16 bits: count of words written, wrapping from 0xFFFF to 0.

Function
REQ-013 A byte SHALL be accepted only in a cycle where in_valid & in_ready.
REQ-014 Accepted bytes SHALL fill lanes little-endian: the first byte goes to data bits [BW-1:0] and byte k goes to [k*BW +: BW].
REQ-015 A lane counter, 0..LANES-1, SHALL increment per accepted byte and wrap to 0 after lane LANES-1.
REQ-016 The block SHALL have states FILL (accumulating) and HOLD (a complete word is in the output register, awaiting write).
REQ-017 FILL -> HOLD: on acceptance of the lane LANES-1 byte, the accumulator SHALL move to the output register on the same edge.
REQ-018 In HOLD, wr_en SHALL equal !full (combinational); data_out SHALL be stable while in HOLD.
REQ-019 HOLD -> FILL: on a cycle with wr_en=1, unless REQ-021 completes another word in that same cycle.
REQ-020 in_ready SHALL be (state==FILL) | (state==HOLD & !full); no byte is accepted while HOLD & full.
REQ-021 A byte accepted in HOLD together with wr_en SHALL land in lane 0 of the emptied accumulator.
  - With LANES=1, that byte completes a new word and the state SHALL stay HOLD.
REQ-022 Latency: wr_en SHALL first be possible in the cycle after the final byte of a word is accepted; sustained throughput SHALL be one byte per cycle with full=0.
REQ-023 wr_en SHALL never be 1 in FILL, and SHALL never be 1 while full=1.
REQ-024 word_cnt SHALL increment by 1 on every cycle where wr_en=1.

Reset
REQ-025 While rstn=0 at a clock edge, the block SHALL go to state FILL with lane counter=0, accumulator=0, data_out=0, word_cnt=0.
  - Outputs after that edge: wr_en=0, in_ready=1.
  - Any partial or held word SHALL be discarded; reset asserted mid-word or in HOLD SHALL behave identically.

Configuration
REQ-026 With PACKER_FLUSH_EN defined, an accepted byte with in_last=1 SHALL complete the word immediately: remaining upper lanes zero-padded, transition to HOLD, lane counter reset to 0.
REQ-027 Without PACKER_FLUSH_EN, in_last SHALL be ignored and words SHALL complete only on a full LANES count.

Structure
REQ-028 Package byte_packer_pkg SHALL hold the state enum (FILL, HOLD) and the default BW/DW constants.
REQ-029 The lane counter, with wrap and clear, SHALL be a separate sub-module lane_counter, parameterised by LANES; everything else SHALL stay in byte_packer.

Verification
REQ-030 Bytes 0x11,0x22,0x33,0x44 on consecutive cycles, full=0 -> next cycle wr_en=1, data_out=0x44332211, word_cnt=1.
REQ-031 Eight back-to-back bytes 0x01..0x08, full=0 -> in_ready held 1; writes 0x04030201 then 0x08070605 four cycles apart; word_cnt=2.
REQ-032 Word completed while full=1 for 3 cycles -> wr_en=0, in_ready=0, data_out stable; write occurs in the cycle full drops.
REQ-033 PACKER_FLUSH_EN defined, bytes 0xAA,0xBB with in_last on 0xBB -> data_out=0x0000BBAA, wr_en=1 the next cycle; undefined -> no write until two more bytes.
REQ-034 rstn=0 asserted after 2 bytes, then bytes 0x11..0x44 -> single word 0x44332211 written; word_cnt=1.
REQ-035 Force word_cnt to 0xFFFF (65535 words), then one more word -> word_cnt=0x0000.
